// File: rtl/taylor_term_stage.sv
// Two-stage Taylor-series iteration: t' = t*x/(n+1), y' = y + t'.
// The registered outputs are fed back upstream as the "past" operands.
module taylor_term_stage #(
   parameter int N_TERMS = 8,
   parameter int COEF_W  = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] y_in,
   input  logic [31:0] t_in,
   input  logic [7:0]  x_in,
   input  logic [3:0]  n_in,
   input  logic        ovf_in,
   input  logic        v_in,
   output logic [31:0] y_out,
   output logic [31:0] t_out,
   output logic [7:0]  x_out,
   output logic [3:0]  n_out,
   output logic        ovf_out,
   output logic        v_out,
   output logic        last_out
);

   localparam int PROD_W = 32 + COEF_W;

   // Reciprocal table floor(65536/(k+1)) in Q1.16.
   function automatic logic [COEF_W-1:0] recip_lut(input logic [3:0] k);
      logic [COEF_W-1:0] c;
      case (k)
         4'd0:    c = 17'd65536;
         4'd1:    c = 17'd32768;
         4'd2:    c = 17'd21845;
         4'd3:    c = 17'd16384;
         4'd4:    c = 17'd13107;
         4'd5:    c = 17'd10922;
         4'd6:    c = 17'd9362;
         4'd7:    c = 17'd8192;
         4'd8:    c = 17'd7281;
         4'd9:    c = 17'd6553;
         4'd10:   c = 17'd5957;
         4'd11:   c = 17'd5461;
         4'd12:   c = 17'd5041;
         4'd13:   c = 17'd4681;
         4'd14:   c = 17'd4369;
         4'd15:   c = 17'd4096;
         default: c = 17'd0;
      endcase
      return c;
   endfunction

   logic [31:0]       p1_r;
   logic [31:0]       y1_r;
   logic [7:0]        x1_r;
   logic [3:0]        n1_r;
   logic              ovf1_r;
   logic              v1_r;

   logic [31:0]       y_r;
   logic [31:0]       t_r;
   logic [7:0]        x_r;
   logic [3:0]        n_r;
   logic              ovf_r;
   logic              v_r;
   logic              last_r;

   logic [39:0]       prod1_s;
   logic [31:0]       p1_next_s;
   logic [COEF_W-1:0] coef_s;
   logic [PROD_W-1:0] prod2_s;
   logic [31:0]       t_next_s;
   logic [32:0]       sum_s;
   logic [31:0]       y_next_s;
   logic              ovf_next_s;
   logic [3:0]        n_next_s;
   logic              last_next_s;

   // Stage-1 datapath: scale the term by x (Q0.8), keeping Q16.16.
   always_comb begin
      prod1_s   = {8'd0, t_in} * {32'd0, x_in};
      p1_next_s = 32'(prod1_s >> 8);
   end

   // Stage-2 datapath: divide by (n+1), accumulate with saturation.
   always_comb begin
      coef_s      = recip_lut(n1_r);
      prod2_s     = PROD_W'(p1_r) * PROD_W'(coef_s);
      t_next_s    = 32'(prod2_s >> 16);
      sum_s       = {1'b0, y1_r} + {1'b0, t_next_s};
      y_next_s    = sum_s[31:0];
      ovf_next_s  = ovf1_r;
      if (sum_s[32]) begin
         y_next_s   = 32'hFFFF_FFFF;
         ovf_next_s = 1'b1;
      end else begin
         y_next_s   = sum_s[31:0];
         ovf_next_s = ovf1_r;
      end
      if (n1_r == 4'd15) begin
         n_next_s = 4'd15;
      end else begin
         n_next_s = n1_r + 4'd1;
      end
      last_next_s = v1_r && (n_next_s == 4'(N_TERMS));
   end

   // Stage-1 registers; data only loads for valid entries so bubbles hold it.
   always_ff @(posedge clk) begin
      if (rst) begin
         p1_r   <= 32'd0;
         y1_r   <= 32'd0;
         x1_r   <= 8'd0;
         n1_r   <= 4'd0;
         ovf1_r <= 1'b0;
         v1_r   <= 1'b0;
      end else if (flush) begin
         v1_r <= 1'b0;
      end else if (!stall) begin
         v1_r <= v_in;
         if (v_in) begin
            p1_r   <= p1_next_s;
            y1_r   <= y_in;
            x1_r   <= x_in;
            n1_r   <= n_in;
            ovf1_r <= ovf_in;
         end
      end
   end

   // Stage-2 (output) registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_r    <= 32'd0;
         t_r    <= 32'd0;
         x_r    <= 8'd0;
         n_r    <= 4'd0;
         ovf_r  <= 1'b0;
         v_r    <= 1'b0;
         last_r <= 1'b0;
      end else if (flush) begin
         v_r    <= 1'b0;
         last_r <= 1'b0;
      end else if (!stall) begin
         v_r    <= v1_r;
         last_r <= last_next_s;
         if (v1_r) begin
            y_r   <= y_next_s;
            t_r   <= t_next_s;
            x_r   <= x1_r;
            n_r   <= n_next_s;
            ovf_r <= ovf_next_s;
         end
      end
   end

   assign y_out    = y_r;
   assign t_out    = t_r;
   assign x_out    = x_r;
   assign n_out    = n_r;
   assign ovf_out  = ovf_r;
   assign v_out    = v_r;
   assign last_out = last_r;

endmodule

// File: tb/tb_taylor_term_stage.sv
// Scoreboard bench for taylor_term_stage: expectations queued at issue,
// compared when v_out reports a fresh result.
module tb_taylor_term_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [31:0] y_in, t_in;
   logic [7:0]  x_in;
   logic [3:0]  n_in;
   logic        ovf_in, v_in;
   logic [31:0] y_out, t_out;
   logic [7:0]  x_out;
   logic [3:0]  n_out;
   logic        ovf_out, v_out, last_out;

   typedef struct packed {
      logic [31:0] y;
      logic [31:0] t;
      logic [7:0]  x;
      logic [3:0]  n;
      logic        ovf;
      logic        last;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   logic adv, held;
   logic [63:0] snap_data;
   logic [14:0] snap_ctl;

   taylor_term_stage #(.N_TERMS(8), .COEF_W(17)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .y_in(y_in), .t_in(t_in), .x_in(x_in), .n_in(n_in),
      .ovf_in(ovf_in), .v_in(v_in),
      .y_out(y_out), .t_out(t_out), .x_out(x_out), .n_out(n_out),
      .ovf_out(ovf_out), .v_out(v_out), .last_out(last_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t make_exp(input logic [31:0] y, input logic [31:0] t,
                                     input logic [7:0] x, input logic [3:0] n,
                                     input logic ovf, input logic last);
      exp_t e;
      e.y = y; e.t = t; e.x = x; e.n = n; e.ovf = ovf; e.last = last;
      return e;
   endfunction

   // Reference arithmetic: divide by (n+1) directly rather than via a table.
   function automatic exp_t model(input logic [31:0] y, input logic [31:0] t,
                                  input logic [7:0] x, input logic [3:0] n,
                                  input logic ovf);
      logic [63:0] tt, xx, p1, tn, sum, coef;
      exp_t e;
      tt   = {32'd0, t};
      xx   = {56'd0, x};
      p1   = (tt * xx) >> 8;
      coef = 64'(65536 / (int'(n) + 1));
      tn   = (p1 * coef) >> 16;
      sum  = {32'd0, y} + tn;
      e.t  = tn[31:0];
      if (sum > 64'h0000_0000_FFFF_FFFF) begin
         e.y = 32'hFFFF_FFFF; e.ovf = 1'b1;
      end else begin
         e.y = sum[31:0]; e.ovf = ovf;
      end
      e.n    = (n == 4'd15) ? 4'd15 : n + 4'd1;
      e.x    = x;
      e.last = (e.n == 4'd8);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] y, input logic [31:0] t, input logic [7:0] x,
                        input logic [3:0] n, input logic ovf);
      y_in = y; t_in = t; x_in = x; n_in = n; ovf_in = ovf; v_in = 1'b1;
   endtask

   task automatic send(input logic [31:0] y, input logic [31:0] t, input logic [7:0] x,
                       input logic [3:0] n, input logic ovf);
      drive(y, t, x, n, ovf);
      sb.push_back(model(y, t, x, n, ovf));
      tick();
   endtask

   task automatic send_exp(input logic [31:0] y, input logic [31:0] t, input logic [7:0] x,
                           input logic [3:0] n, input logic ovf, input exp_t e);
      drive(y, t, x, n, ovf);
      sb.push_back(e);
      tick();
   endtask

   task automatic bubble();
      v_in = 1'b0;
      y_in = $urandom; t_in = $urandom; x_in = 8'($urandom); n_in = 4'($urandom);
      tick();
   endtask

   // Note whether the last edge advanced the pipeline or held it.
   always @(posedge clk) begin
      adv  <= !rst && !flush && !stall;
      held <= !rst && !flush && stall;
   end

   // Output monitor: score fresh results, and check frozen outputs while stalled.
   always @(negedge clk) begin
      if (adv === 1'b1) begin
         if (v_out) begin
            if (sb.size() == 0) begin
               chk("unexpected_v_out", 64'(v_out), 64'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("y_out", 64'(y_out), 64'(mon_e.y));
               chk("t_out", 64'(t_out), 64'(mon_e.t));
               chk("x_out", 64'(x_out), 64'(mon_e.x));
               chk("n_out", 64'(n_out), 64'(mon_e.n));
               chk("ovf_out", 64'(ovf_out), 64'(mon_e.ovf));
               chk("last_out", 64'(last_out), 64'(mon_e.last));
            end
         end else begin
            chk("last_without_valid", 64'(last_out), 64'd0);
         end
      end else if (held === 1'b1) begin
         chk("stall_hold_data", {y_out, t_out}, snap_data);
         chk("stall_hold_ctl", 64'({x_out, n_out, ovf_out, v_out, last_out}), 64'(snap_ctl));
      end
      snap_data = {y_out, t_out};
      snap_ctl  = {x_out, n_out, ovf_out, v_out, last_out};
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      y_in = 32'd0; t_in = 32'd0; x_in = 8'd0; n_in = 4'd0; ovf_in = 1'b0; v_in = 1'b0;
      tick(); tick();
      chk("reset_data", {y_out, t_out}, 64'd0);
      chk("reset_ctl", 64'({x_out, n_out, ovf_out, v_out, last_out}), 64'd0);
      rst = 1'b0;
      bubble();

      // Directed values, hand-computed.
      send_exp(32'h0001_0000, 32'h0001_0000, 8'h80, 4'd0, 1'b0,
               make_exp(32'h0001_8000, 32'h0000_8000, 8'h80, 4'd1, 1'b0, 1'b0));
      send_exp(32'h0001_8000, 32'h0000_8000, 8'h80, 4'd1, 1'b0,
               make_exp(32'h0001_A000, 32'h0000_2000, 8'h80, 4'd2, 1'b0, 1'b0));
      send_exp(32'h0001_A000, 32'h0000_2000, 8'h80, 4'd7, 1'b0,
               make_exp(32'h0001_A200, 32'h0000_0200, 8'h80, 4'd8, 1'b0, 1'b1));
      send_exp(32'hFFFF_0000, 32'h0002_0000, 8'hFF, 4'd0, 1'b0,
               make_exp(32'hFFFF_FFFF, 32'h0001_FE00, 8'hFF, 4'd1, 1'b1, 1'b0));
      send_exp(32'h0001_0000, 32'h0001_0000, 8'h80, 4'd0, 1'b1,
               make_exp(32'h0001_8000, 32'h0000_8000, 8'h80, 4'd1, 1'b1, 1'b0));
      send_exp(32'h0000_0000, 32'h0001_0000, 8'hFF, 4'd15, 1'b0,
               make_exp(32'h0000_0FF0, 32'h0000_0FF0, 8'hFF, 4'd15, 1'b0, 1'b0));
      bubble(); bubble(); bubble();

      // Stall with two entries in flight; garbage on the inputs must be ignored.
      send(32'h0003_0000, 32'h0000_4000, 8'h40, 4'd3, 1'b0);
      send(32'h0000_1234, 32'h0012_3456, 8'hC3, 4'd5, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, 8'($urandom), 4'($urandom), 1'b1);
         tick();
      end
      stall = 1'b0;
      bubble(); bubble(); bubble();

      // Flush together with stall drops both in-flight entries.
      send(32'h0000_0100, 32'h0100_0000, 8'h10, 4'd2, 1'b0);
      send(32'h0000_0200, 32'h0200_0000, 8'h20, 4'd4, 1'b0);
      flush = 1'b1; stall = 1'b1; v_in = 1'b0;
      tick();
      flush = 1'b0; stall = 1'b0;
      sb.delete();
      chk("flush_v_cycle1", 64'(v_out), 64'd0);
      bubble();
      chk("flush_v_cycle2", 64'(v_out), 64'd0);
      bubble();

      // Reset during valid traffic discards everything in flight.
      send(32'h0000_0300, 32'h0300_0000, 8'h30, 4'd1, 1'b0);
      send(32'h0000_0400, 32'h0400_0000, 8'h40, 4'd6, 1'b1);
      rst = 1'b1;
      drive(32'h0000_0500, 32'h0500_0000, 8'h50, 4'd7, 1'b0);
      tick(); tick();
      sb.delete();
      chk("midrst_data", {y_out, t_out}, 64'd0);
      chk("midrst_ctl", 64'({x_out, n_out, ovf_out, v_out, last_out}), 64'd0);
      rst = 1'b0;
      bubble(); bubble(); bubble();

      // Random traffic with bubbles and stalls.
      for (int i = 0; i < 80; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            stall = 1'b1;
            drive($urandom, $urandom, 8'($urandom), 4'($urandom), 1'($urandom));
            tick();
            stall = 1'b0;
         end else if (r < 4) begin
            bubble();
         end else begin
            send($urandom, $urandom, 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         end
      end
      bubble(); bubble(); bubble(); bubble();
      chk("drain_scoreboard", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/taylor_term_stage.md
Name: taylor_term_stage

Overview:
- Iteration stage of the series evaluator. It sits directly downstream of the past/new operand mux group and consumes its selected y, t, x, n, ovf and v.
- Each accepted entry produces the next series term t' = t·x/(n+1) and the updated partial sum y' = y + t', two cycles later.
- Its registered outputs are the "past" operands fed back into the mux group on the next iteration.
- Fixed point formats: y and t are unsigned Q16.16; x is unsigned Q0.8 (value x/256).

Parameters:
- N_TERMS, 8: iteration index at which an entry is complete; drives last_out.
- COEF_W, 17: width of the reciprocal LUT entries, Q1.16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold both pipeline stages.
- flush  input  1  drop all in-flight entries.
- y_in  input  32  partial sum, Q16.16.
- t_in  input  32  current term, Q16.16.
- x_in  input  8  argument, Q0.8.
- n_in  input  4  iteration index of t_in.
- ovf_in  input  1  sticky overflow carried with the entry.
- v_in  input  1  entry valid.
- y_out  output  32  updated partial sum.
- t_out  output  32  next term.
- x_out  output  8  argument passed through.
- n_out  output  4  index of t_out.
- ovf_out  output  1  sticky overflow.
- v_out  output  1  output valid.
- last_out  output  1  v_out & (n_out == N_TERMS).

Behaviour:
- Reset: rst=1 at a rising edge clears all stage-1 and stage-2 registers. All outputs then read 0, including v_out and last_out. Reset mid-operation discards in-flight entries with no partial output.
- Pipeline: two register stages, latency exactly 2 cycles from a sampled v_in=1 to v_out=1. With no stall, throughput is one entry per cycle.
- Stage 1 captures:
  - p1 = (t_in·x_in)[39:8], using a 40-bit product.
  - y_in, x_in, n_in, ovf_in, v_in.
- Stage 2 computes from the stage-1 registers:
  - coef = LUT[n1], where LUT[k] = floor(65536/(k+1)) for k = 0..15. Examples: LUT[0]=65536, LUT[1]=32768, LUT[2]=21845, LUT[15]=4096.
  - t_out = (p1·coef)[47:16], using a 49-bit product. The result never exceeds p1, so t_out cannot overflow.
  - sum = {1'b0,y1} + {1'b0,t_out}, 33 bits wide.
  - If sum[32]=1: y_out = 32'hFFFFFFFF and ovf_out = 1. Otherwise y_out = sum[31:0] and ovf_out = ovf1.
  - ovf is sticky: once set on an entry it stays set for that entry.
  - n_out = n1+1, saturating at 15 (n1=15 gives n_out=15).
  - x_out = x1, v_out = v1.
- Bubbles: an entry with v=0 still advances through the stages as v=0. Its data registers hold their previous values. v_out=0 implies last_out=0.
- stall=1: both stages hold every register, including v; inputs are ignored that cycle. Upstream must keep its operands stable, or re-present them, while stall=1.
- flush=1: both stage valid bits clear on the next edge. Data registers are don't-care.
- Precedence on the same edge: rst > flush > stall.
- Back-to-back entries need not share x or n; the stages carry no per-entry state beyond the pipeline registers.
- Combinational logic: the LUT is a constant case table, with no ROM init file.

Test Plan:
- Reset: assert rst for 2 cycles during valid traffic → next cycle all outputs 0; no v_out pulse afterwards from pre-reset entries.
- Single entry: y=t=0x00010000, x=0x80, n=0, v=1 → two cycles later t_out=0x00008000, y_out=0x00018000, n_out=1, ovf_out=0, v_out=1.
- Chained iteration: y=0x00018000, t=0x00008000, x=0x80, n=1 → t_out=0x00002000, y_out=0x0001A000, n_out=2. Then feed back with n=7 until n_out=8 → last_out=1 for exactly one cycle.
- Overflow: y=0xFFFF0000, t=0x00020000, x=0xFF, n=0 → t_out=0x0001FE00, y_out=0xFFFFFFFF, ovf_out=1. Feeding back any entry with ovf_in=1 → ovf_out stays 1.
- Stall: assert stall for 3 cycles with 2 entries in flight → outputs frozen. After release, both entries emerge in order on consecutive cycles with correct values.
- Flush with stall: flush=1 and stall=1 on the same edge with 2 entries in flight → v_out=0 for the next 2 cycles. Index saturation: n_in=15 → n_out=15, coef=4096.
